// File: rtl/pix_frame_packer.sv
// rtl/pix_frame_packer.sv - frames SPAD pixel words with a header (and an optional trailer) into the host FIFO
// Optional feature macro: FRAME_TRAILER_EN (adds TRL_WORD + 16-bit pixel-count checksum after each frame)
module pix_frame_packer #(
  parameter int          BUF_AW   = 3,
  parameter logic [15:0] HDR_WORD = 16'hCCCC,
  parameter logic [15:0] TRL_WORD = 16'hAAAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr_stat,
  input  logic [15:0] pix_word,
  input  logic        pix_valid,
  input  logic        fifo_full,
  output logic [15:0] fifo_din,
  output logic        fifo_wr,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic        seq_err,
  output logic        busy
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam logic [BUF_AW:0] DEPTH_CNT = DEPTH[BUF_AW:0];

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PIX, TRL0, TRL1, DROP} state_t;

  state_t              state, nxt;
  logic [15:0]         mem [DEPTH];
  logic [BUF_AW-1:0]   wptr, rptr;
  logic [BUF_AW:0]     count;
  logic                ovf;
  logic [9:0]          exp_addr;
  logic [15:0]         head;
  logic [9:0]          head_addr;
  logic                empty, full, push, pop;
  logic                emit, frame_inc, drop_inc, seq_set, ovf_clr, exp_clr, exp_inc;
  logic [15:0]         emit_word;
`ifdef FRAME_TRAILER_EN
  logic [15:0]         csum;
`else
  logic                unused_trl;
  assign unused_trl = ^TRL_WORD;
`endif

  assign head      = mem[rptr];
  assign head_addr = head[15:6];
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  // A full buffer still takes the new word when the head leaves in the same cycle.
  assign push      = pix_valid && (!full || pop);
  assign busy      = (state != IDLE) || !empty;

  // Next-state and per-cycle actions; overflow abort outranks normal framing.
  always_comb begin
    nxt       = state;
    pop       = 1'b0;
    emit      = 1'b0;
    emit_word = 16'h0000;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    seq_set   = 1'b0;
    ovf_clr   = 1'b0;
    exp_clr   = 1'b0;
    exp_inc   = 1'b0;
    if (ovf && state != IDLE && state != DROP) begin
      drop_inc = 1'b1;
      ovf_clr  = 1'b1;
      nxt      = DROP;
    end else begin
      case (state)
        IDLE: begin
          ovf_clr = 1'b1;
          if (!empty) begin
            if (head_addr == 10'd0 && en) nxt = HDR0;
            else pop = 1'b1;
          end
        end
        HDR0: if (!fifo_full) begin
          emit      = 1'b1;
          emit_word = HDR_WORD;
          nxt       = HDR1;
        end
        HDR1: if (!fifo_full) begin
          emit      = 1'b1;
          emit_word = frame_cnt;
          exp_clr   = 1'b1;
          nxt       = PIX;
        end
        PIX: if (!empty) begin
          // A mismatched head stays in the buffer so that an early addr-0 word can still open the next frame.
          if (head_addr != exp_addr) begin
            seq_set  = 1'b1;
            drop_inc = 1'b1;
            nxt      = DROP;
          end else if (!fifo_full) begin
            pop       = 1'b1;
            emit      = 1'b1;
            emit_word = head;
            exp_inc   = 1'b1;
            if (exp_addr == 10'd511) begin
`ifdef FRAME_TRAILER_EN
              nxt = TRL0;
`else
              frame_inc = 1'b1;
              nxt       = IDLE;
`endif
            end
          end
        end
`ifdef FRAME_TRAILER_EN
        TRL0: if (!fifo_full) begin
          emit      = 1'b1;
          emit_word = TRL_WORD;
          nxt       = TRL1;
        end
        TRL1: if (!fifo_full) begin
          emit      = 1'b1;
          emit_word = csum;
          frame_inc = 1'b1;
          nxt       = IDLE;
        end
`endif
        DROP: begin
          ovf_clr = 1'b1;
          if (!empty) begin
            if (head_addr == 10'd0) nxt = IDLE;
            else pop = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Buffer storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= pix_word;
  end

  // Buffer pointers, occupancy and the lost-write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{BUF_AW{1'b0}}, push} - {{BUF_AW{1'b0}}, pop};
      if (pix_valid && !push) ovf <= 1'b1;
      else if (ovf_clr)       ovf <= 1'b0;
    end
  end

  // Registered host FIFO write port; fifo_din holds its last word between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr  <= 1'b0;
      fifo_din <= 16'h0000;
    end else begin
      fifo_wr <= emit;
      if (emit) fifo_din <= emit_word;
    end
  end

  // Statistics; clr_stat wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'h0000;
      drop_cnt  <= 16'h0000;
      seq_err   <= 1'b0;
    end else if (clr_stat) begin
      frame_cnt <= 16'h0000;
      drop_cnt  <= 16'h0000;
      seq_err   <= 1'b0;
    end else begin
      if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (seq_set) seq_err <= 1'b1;
    end
  end

  // Expected pixel address (and checksum when the trailer is built in) for the frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_addr <= 10'd0;
`ifdef FRAME_TRAILER_EN
      csum     <= 16'h0000;
`endif
    end else if (exp_clr) begin
      exp_addr <= 10'd0;
`ifdef FRAME_TRAILER_EN
      csum     <= 16'h0000;
`endif
    end else if (exp_inc) begin
      exp_addr <= exp_addr + 10'd1;
`ifdef FRAME_TRAILER_EN
      csum     <= csum + {11'd0, head[4:0]};
`endif
    end
  end

endmodule

// File: tb/tb_pix_frame_packer.sv
// tb/tb_pix_frame_packer.sv - directed scoreboard bench for pix_frame_packer
module tb_pix_frame_packer;

  logic        clk = 1'b0;
  logic        rst, en, clr_stat, pix_valid, fifo_full;
  logic [15:0] pix_word;
  logic [15:0] fifo_din, frame_cnt, drop_cnt;
  logic        fifo_wr, seq_err, busy;

  logic [15:0] sb [$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_fc   = 16'h0000;
  logic        mon_full;

  pix_frame_packer dut (
    .clk(clk), .rst(rst), .en(en), .clr_stat(clr_stat),
    .pix_word(pix_word), .pix_valid(pix_valid), .fifo_full(fifo_full),
    .fifo_din(fifo_din), .fifo_wr(fifo_wr), .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt), .seq_err(seq_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every host write must be expected and must follow a not-full sample.
  always @(posedge clk) begin
    mon_full = fifo_full;
    #1;
    if (fifo_wr === 1'b1) begin
      check("wr_while_full", {31'd0, mon_full}, 32'd0);
      if (sb.size() == 0) check("unexpected_wr_sb_size", 32'd0, 32'd1);
      else check("fifo_din", {16'd0, fifo_din}, {16'd0, sb.pop_front()});
    end
  end

  task automatic send_word(input int a);
    logic [9:0] ad;
    ad = a[9:0];
    @(negedge clk);
    pix_word  = {ad, 1'b0, ad[4:0]};
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  // Drives addresses first..last (skipping 'skip'), pushes the first n_emit as expected output,
  // and holds fifo_full for full_len clocks starting after word full_at.
  task automatic send_frame(input int first, input int last, input int skip,
                            input int full_at, input int full_len, input int n_emit);
    for (int a = first; a <= last; a++) begin
      if (a != skip) begin
        if (a - first < n_emit) begin
          logic [9:0] ad;
          ad = a[9:0];
          sb.push_back({ad, 1'b0, ad[4:0]});
        end
        send_word(a);
      end
      if (a == full_at) fifo_full = 1'b1;
      if (full_at >= 0 && a == full_at + full_len / 2) fifo_full = 1'b0;
    end
  endtask

  task automatic good_frame(input int full_at, input int full_len);
    sb.push_back(16'hCCCC);
    sb.push_back(exp_fc);
    send_frame(0, 511, -1, full_at, full_len, 512);
`ifdef FRAME_TRAILER_EN
    sb.push_back(16'hAAAA);
    sb.push_back(16'h1F00);
`endif
    exp_fc = exp_fc + 16'd1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_sb_left", sb.size(), 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
    exp_fc = 16'h0000;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr_stat = 1'b0; pix_valid = 1'b0;
    fifo_full = 1'b0; pix_word = 16'h0000;

    // Reset with pix_valid toggling.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pix_valid = ~pix_valid;
      pix_word  = 16'h0000;
    end
    pix_valid = 1'b0;
    check("rst_fifo_din",  {16'd0, fifo_din}, 32'd0);
    check("rst_fifo_wr",   {31'd0, fifo_wr}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_drop_cnt",  {16'd0, drop_cnt}, 32'd0);
    check("rst_seq_err",   {31'd0, seq_err}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Plain frame.
    good_frame(-1, 0);
    drain();
    check("f1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("f1_drop_cnt",  {16'd0, drop_cnt}, 32'd0);
    check("f1_seq_err",   {31'd0, seq_err}, 32'd0);

    // Short backpressure at addr 200: no loss.
    good_frame(200, 6);
    drain();
    check("f2_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    check("f2_drop_cnt",  {16'd0, drop_cnt}, 32'd0);

    pulse_clr();
    check("clr1_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    // Long backpressure: overflow aborts the frame, the next one is clean.
    sb.push_back(16'hCCCC);
    sb.push_back(exp_fc);
    send_frame(0, 511, -1, 100, 40, 100);
    check("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    good_frame(-1, 0);
    drain();
    check("ovf_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("ovf_drop_cnt2", {16'd0, drop_cnt}, 32'd1);
    check("ovf_seq_err",   {31'd0, seq_err}, 32'd0);

    pulse_clr();

    // Missing addr 100: sequence error, frame aborted after addr 99.
    sb.push_back(16'hCCCC);
    sb.push_back(exp_fc);
    send_frame(0, 511, 100, -1, 0, 100);
    check("seq_seq_err",  {31'd0, seq_err}, 32'd1);
    check("seq_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    good_frame(-1, 0);
    drain();
    check("seq_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    pulse_clr();
    check("clr2_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("clr2_drop_cnt",  {16'd0, drop_cnt}, 32'd0);
    check("clr2_seq_err",   {31'd0, seq_err}, 32'd0);

    // Stream joined at addr 300: silent until the next addr-0 word.
    send_frame(300, 511, -1, -1, 0, 0);
    good_frame(-1, 0);
    drain();
    check("late_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // en low: a frame start is discarded; re-enabling accepts the next frame.
    en = 1'b0;
    send_frame(0, 40, -1, -1, 0, 0);
    en = 1'b1;
    good_frame(-1, 0);
    drain();
    check("en_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    check("en_drop_cnt",  {16'd0, drop_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
